// File: rtl/resnet_pkg.sv
// Shared types and helpers for the ResNet datapath stages (partial sum, BN, RPReLU).
// Latency: none, because this file holds only types, constants and a combinational function.
// Backpressure: none.
package resnet_pkg;

   // Width of the int8 activation bus between stages.
   localparam int OUT_W = 8;

   // Widest accumulator sat8 accepts. Callers sign-extend into it.
   localparam int SAT_IN_W = 32;

   // Beat-count width. This is enough for any kernel up to 255 taps.
   localparam int CNT_W = 8;
   typedef logic [CNT_W-1:0] cnt_t;

   // The partial-sum stage derives its view of the accumulation from the beat counter.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_LAST  = 2'd2
   } ps_state_e;

   typedef struct packed {
      logic                    ovf;
      logic signed [OUT_W-1:0] val;
   } sat8_t;

   localparam logic signed [SAT_IN_W-1:0] INT8_MAX = 127;
   localparam logic signed [SAT_IN_W-1:0] INT8_MIN = -128;

   // Clamp a signed value to int8, and flag whether the clamp changed the value.
   function automatic sat8_t sat8(input logic signed [SAT_IN_W-1:0] v);
      sat8_t r;
      r.ovf = 1'b0;
      r.val = v[OUT_W-1:0];
      if (v > INT8_MAX) begin
         r.ovf = 1'b1;
         r.val = 8'sh7F;
      end else if (v < INT8_MIN) begin
         r.ovf = 1'b1;
         r.val = 8'sh80;
      end
      return r;
   endfunction

endpackage

// File: rtl/partial_sum_lane.sv
// Single-channel accumulator with int8 saturation on the final beat.
// Latency: the result register updates on the edge that captures the last beat.
// Backpressure: none, so the lane acts on every qualified beat.
module partial_sum_lane
   import resnet_pkg::*;
#(
   parameter int IN_WIDTH  = 6,
   parameter int ACC_WIDTH = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    beat_i,   // valid beat, not cancelled by clear
   input  logic                    start_i,  // this beat restarts the sum
   input  logic                    last_i,   // this beat completes the sum
   input  logic [IN_WIDTH-1:0]     din_i,
   output logic [OUT_W-1:0]        dout_o,
   output logic                    ovf_o     // final sum out of int8 range (meaningful with last_i)
);

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic        [OUT_W-1:0]     dout_q, dout_d;
   logic signed [ACC_WIDTH-1:0] din_ext;
   logic signed [ACC_WIDTH-1:0] sum;
   sat8_t                       sat;

   // A start beat ignores the stale accumulator, so a clear never has to scrub acc.
   always_comb begin
      din_ext = {{(ACC_WIDTH-IN_WIDTH){din_i[IN_WIDTH-1]}}, din_i};
      sum     = (start_i ? '0 : acc_q) + din_ext;
      sat     = sat8({{(SAT_IN_W-ACC_WIDTH){sum[ACC_WIDTH-1]}}, sum});
      acc_d   = acc_q;
      dout_d  = dout_q;
      if (beat_i) begin
         acc_d = sum;
         if (last_i) dout_d = sat.val;
      end
   end

   // The accumulator and the held result register.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         dout_q <= '0;
      end else begin
         acc_q  <= acc_d;
         dout_q <= dout_d;
      end
   end

   assign dout_o = dout_q;
   assign ovf_o  = sat.ovf;

endmodule

// File: rtl/partial_sum.sv
// Accumulates STEPS valid beats per channel and emits saturated int8 results.
// Latency: data_out_valid pulses on the cycle after the final beat.
// Backpressure: none, because the downstream stage always accepts.
module partial_sum
   import resnet_pkg::*;
#(
   parameter int CHANNEL_NUM = 128,
   parameter int IN_WIDTH    = 6,
   parameter int STEPS       = 9,
   parameter int ACC_WIDTH   = 12
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                data_in_valid,
   input  logic                                clear,
   input  logic        [CHANNEL_NUM*IN_WIDTH-1:0] data_in,
   output logic signed [CHANNEL_NUM*OUT_W-1:0]    data_out,
   output logic                                data_out_valid,
   output logic                                sat_flag
);

   cnt_t             cnt_q, cnt_d;
   logic             vld_q, vld_d;
   logic             sat_q, sat_d;
   ps_state_e        state;
   logic             beat;
   logic [CHANNEL_NUM-1:0] ovf;

   // A beat coinciding with clear is dropped entirely.
   assign beat = data_in_valid & ~clear;

   // Decode the accumulation phase. LAST is tested first so that STEPS == 1 makes every beat final.
   always_comb begin
      state = ST_ACCUM;
      if (cnt_q == cnt_t'(STEPS - 1)) state = ST_LAST;
      else if (cnt_q == '0)           state = ST_IDLE;
   end

   // Next-state logic for the beat counter and the output pulses.
   always_comb begin
      cnt_d = cnt_q;
      vld_d = 1'b0;
      sat_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (data_in_valid) begin
         if (state == ST_LAST) begin
            cnt_d = '0;
            vld_d = 1'b1;
            sat_d = |ovf;
         end else begin
            cnt_d = cnt_t'(cnt_q + 1'b1);
         end
      end
   end

   // The beat counter and the registered valid/flag pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         vld_q <= 1'b0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         vld_q <= vld_d;
         sat_q <= sat_d;
      end
   end

   for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_lane
      partial_sum_lane #(
         .IN_WIDTH  (IN_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .beat_i  (beat),
         .start_i (cnt_q == '0),
         .last_i  (state == ST_LAST),
         .din_i   (data_in[i*IN_WIDTH +: IN_WIDTH]),
         .dout_o  (data_out[i*OUT_W +: OUT_W]),
         .ovf_o   (ovf[i])
      );
   end

   assign data_out_valid = vld_q;
   assign sat_flag       = sat_q;

endmodule

// File: tb/tb_partial_sum.sv
// Self-checking bench for partial_sum, with a scoreboard of expected results.
// Latency: each expected result is due one cycle after its final beat.
// Backpressure: none.
module tb_partial_sum;

   localparam int CH = 128;
   localparam int IW = 6;
   localparam int ST = 9;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                data_in_valid = 1'b0;
   logic                clear = 1'b0;
   logic [CH*IW-1:0]    data_in = '0;
   logic signed [CH*8-1:0] data_out;
   logic                data_out_valid;
   logic                sat_flag;

   partial_sum #(
      .CHANNEL_NUM (CH),
      .IN_WIDTH    (IW),
      .STEPS       (ST),
      .ACC_WIDTH   (12)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in_valid  (data_in_valid),
      .clear          (clear),
      .data_in        (data_in),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .sat_flag       (sat_flag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int e0;
      int e1;
      int er;
      bit sat;
      int due;
   } exp_t;

   exp_t sb[$];
   int   last_e0 = 0;

   typedef struct {
      int v0;
      int v1;
      int vr;
      int e0;
      int e1;
      int er;
      bit sat;
   } vec_t;

   function automatic int get_out(input int ch);
      logic signed [7:0] t;
      t = data_out[ch*8 +: 8];
      return int'(t);
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Channels 2..CH-1 are compared as a group. The first channel that differs is reported.
   task automatic check_rest(input string name, input int req);
      int bad;
      bad = -1;
      for (int c = 2; c < CH; c++)
         if (bad < 0 && get_out(c) != req) bad = c;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: channel %0d got %0d, expected %0d", name, bad, get_out(bad), req);
      end
   endtask

   // The monitor checks every pulse against the scoreboard, flags pulses that were
   // not expected, and flags expected results that never arrived.
   always @(negedge clk) begin
      if (!rst) begin
         if (data_out_valid) begin
            if (sb.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("latency", cyc, e.due);
               check("out_ch0", get_out(0), e.e0);
               check("out_ch1", get_out(1), e.e1);
               check_rest("out_rest", e.er);
               check("sat_flag", int'(sat_flag), int'(e.sat));
               last_e0 = e.e0;
            end
         end else begin
            if (sat_flag) check("sat_without_valid", 1, 0);
            if (sb.size() != 0 && cyc > sb[0].due) begin
               check("missing_valid", 0, 1);
               void'(sb.pop_front());
            end
         end
      end
   end

   // Drive one cycle of stimulus. When push is set, the expected result is queued as well.
   task automatic step(input bit v, input bit c, input int v0, input int v1, input int vr,
                       input bit push, input exp_t e);
      logic [IW-1:0] t;
      for (int ch = 0; ch < CH; ch++) begin
         t = (ch == 0) ? IW'(v0) : (ch == 1) ? IW'(v1) : IW'(vr);
         data_in[ch*IW +: IW] = t;
      end
      data_in_valid = v;
      clear = c;
      if (push) begin
         e.due = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      data_in_valid = 1'b0;
      clear = 1'b0;
   endtask

   task automatic group(input int v0, input int v1, input int vr, input exp_t e);
      for (int b = 0; b < ST; b++)
         step(1'b1, 1'b0, v0, v1, vr, b == ST - 1, e);
   endtask

   task automatic idle(input int n);
      exp_t z;
      z = '{0, 0, 0, 1'b0, 0};
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, 0, 1'b0, z);
   endtask

   task automatic drain();
      int budget;
      budget = 50;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      check("scoreboard_drained", sb.size(), 0);
   endtask

   vec_t vecs[6];
   exp_t e;
   exp_t z;

   initial begin
      vecs[0] = '{3,   3,   3,  27,   27,   27, 1'b0};
      vecs[1] = '{31, -32,  1, 127, -128,    9, 1'b1};
      vecs[2] = '{-1,  -1, -1,  -9,   -9,   -9, 1'b0};
      vecs[3] = '{14, -14,  0, 126, -126,    0, 1'b0};
      vecs[4] = '{15, -15, -3, 127, -128,  -27, 1'b1};
      vecs[5] = '{31,  31, 31, 127,  127,  127, 1'b1};
      z = '{0, 0, 0, 1'b0, 0};

      // Hold reset for 2 cycles, then check the reset state.
      rst = 1'b1;
      @(posedge clk); @(posedge clk);
      #1;
      check("reset_valid", int'(data_out_valid), 0);
      check("reset_sat", int'(sat_flag), 0);
      check("reset_ch0", get_out(0), 0);
      check_rest("reset_rest", 0);
      rst = 1'b0;

      // The table groups are driven back to back, with no idle cycles between them.
      for (int i = 0; i < 6; i++) begin
         e = '{vecs[i].e0, vecs[i].e1, vecs[i].er, vecs[i].sat, 0};
         group(vecs[i].v0, vecs[i].v1, vecs[i].vr, e);
      end
      idle(2);
      drain();

      // Gaps: idle cycles after beats 2 and 6. data_out holds its previous value meanwhile.
      e = '{18, 18, 18, 1'b0, 0};
      for (int b = 0; b < ST; b++) begin
         step(1'b1, 1'b0, 2, 2, 2, b == ST - 1, e);
         if (b == 1 || b == 5) begin
            idle(3);
            check("gap_hold", get_out(0), 127);
         end
      end
      idle(2);
      drain();

      // Clear asserted alone after 5 beats. The partial sum is discarded.
      for (int b = 0; b < 5; b++) step(1'b1, 1'b0, 10, 10, 10, 1'b0, z);
      step(1'b0, 1'b1, 0, 0, 0, 1'b0, z);
      e = '{9, 9, 9, 1'b0, 0};
      group(1, 1, 1, e);
      idle(2);
      drain();

      // Clear coincident with the 9th beat. The beat is dropped and no pulse follows.
      for (int b = 0; b < ST - 1; b++) step(1'b1, 1'b0, 5, 5, 5, 1'b0, z);
      step(1'b1, 1'b1, 5, 5, 5, 1'b0, z);
      idle(3);
      check("clear_last_hold", get_out(0), 9);
      e = '{9, 9, 9, 1'b0, 0};
      group(1, 1, 1, e);
      idle(2);
      drain();

      // Two back-to-back groups whose results have opposite signs.
      e = '{36, 36, 36, 1'b0, 0};
      group(4, 4, 4, e);
      e = '{-36, -36, -36, 1'b0, 0};
      group(-4, -4, -4, e);
      idle(2);
      drain();

      // Reset part-way through a group, then run a clean group.
      for (int b = 0; b < 4; b++) step(1'b1, 1'b0, 7, 7, 7, 1'b0, z);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_ch0", get_out(0), 0);
      check("midrst_valid", int'(data_out_valid), 0);
      check_rest("midrst_rest", 0);
      e = '{9, 9, 9, 1'b0, 0};
      group(1, 1, 1, e);
      idle(3);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Safety net. If the test runs away, report it and stop.
   initial begin
      #200000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule

// File: doc/partial_sum.md
Name: partial_sum

Overview:
- Per-channel accumulator directly upstream of the BN/residual stage. It produces that stage's signed 8-bit `data_in` bus together with its `data_in_valid` strobe.
- Consumes one signed per-kernel-tap partial result per channel per valid beat, from the XNOR/popcount array.
- Accumulates STEPS beats, saturates the total to int8 and presents it with a one-cycle valid pulse.
- No backpressure: the downstream stage always accepts.

Parameters:
- CHANNEL_NUM, 128, number of output channels processed in parallel.
- IN_WIDTH, 6, width of each signed per-beat input value.
- STEPS, 9, beats accumulated per output (kernel taps, e.g. 3x3).
- ACC_WIDTH, 12, signed accumulator width. Must satisfy ACC_WIDTH >= IN_WIDTH + clog2(STEPS) + 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active high.
- data_in_valid  input  1  beat strobe for data_in.
- clear  input  1  synchronous abort; discards any partially accumulated result.
- data_in  input  signed IN_WIDTH x CHANNEL_NUM  per-channel partial value for the current beat.
- data_out  output  signed 8 x CHANNEL_NUM  saturated accumulated result.
- data_out_valid  output  1  one-cycle pulse, result valid.
- sat_flag  output  1  asserted with data_out_valid if any channel saturated in that result.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: beat counter = 0; acc[i] = 0; data_out[i] = 0; data_out_valid = 0; sat_flag = 0. Reset overrides all other inputs and may occur mid-accumulation.
- Beat counter `cnt` runs 0..STEPS-1 and advances only on data_in_valid. Gaps between beats are allowed and leave all state unchanged.
- State view:
  - IDLE is cnt == 0.
  - ACCUM is 0 < cnt < STEPS-1.
  - LAST is cnt == STEPS-1.
- Valid beat in IDLE: acc[i] <= sign-extended data_in[i]; this restarts the sum with no dependence on old acc.
- Valid beat in ACCUM: acc[i] <= acc[i] + sext(data_in[i]).
- Valid beat in LAST:
  - sum[i] = acc[i] + sext(data_in[i]), computed at full ACC_WIDTH.
  - data_out[i] <= sat8(sum[i]).
  - data_out_valid <= 1 on the next edge.
  - sat_flag <= OR over channels of "sum[i] out of range".
  - cnt <= 0.
- Latency: data_out_valid rises on the edge that captures the final beat, i.e. it is visible one cycle after the last data_in_valid.
- sat8 rule: sum > 127 gives 127 (8'h7F); sum < -128 gives -128 (8'h80); otherwise the low 8 bits.
- data_out_valid and sat_flag are single-cycle pulses; both are 0 in every other cycle.
- data_out holds its last value until the next result; it is never zeroed except by rst.
- STEPS == 1: every valid beat is LAST; data_out_valid may then be asserted in consecutive cycles.
- clear, any cycle:
  - cnt <= 0; acc contents become don't-care (overwritten by the next IDLE beat).
  - data_out is held; data_out_valid <= 0; sat_flag <= 0.
  - clear together with data_in_valid: clear wins and the beat is dropped, including a LAST beat (no output pulse).
- A data_in_valid beat in the cycle right after a LAST beat is legal; back-to-back outputs are spaced STEPS valid beats apart.
- No internal overflow: the accumulator is sized so that the only saturation point is the int8 output.

Decomposition:
- Shared package `resnet_pkg`:
  - localparam for the int8 output width.
  - function sat8(input signed [ACC_WIDTH-1:0]) returning logic signed [7:0] plus an overflow bit; reusable by the BN and RPReLU stages.
  - typedef for the beat-count type.
- One natural sub-module, `partial_sum_lane`:
  - a single-channel accumulator plus saturation, generated CHANNEL_NUM times;
  - the beat counter, FSM and valid/flag logic stay in the parent.

Test Plan:
- Basic sum: rst high for 2 cycles, then 9 back-to-back beats with data_in[i] = 3 on all channels -> data_out_valid pulses exactly one cycle after beat 9; data_out[i] = 27; sat_flag = 0.
- Saturation: 9 beats of +31 (sum 279) on channel 0 and 9 beats of -32 (sum -288) on channel 1 -> data_out[0] = 127, data_out[1] = -128, sat_flag = 1; channels carrying 1 per beat give 9.
- Gaps: 9 beats of value 2, with 3 idle cycles inserted after beats 2 and 6 -> single pulse after beat 9; data_out = 18; no pulse during gaps; data_out stays at its prior value until then.
- Clear: 5 beats of 10, then clear asserted alone, then 9 beats of 1 -> output 9, not 59. A second run with clear coincident with the 9th beat -> no pulse, and the next 9-beat group of 1 gives 9.
- Back-to-back groups: 18 consecutive beats (9 beats of 4, then 9 beats of -4) -> pulses at cycle offsets 9 and 18 after the first beat, with data_out 36 then -36.
- Reset mid-accumulation: 4 beats of 7, rst for 1 cycle, then 9 beats of 1 -> all outputs 0 immediately after rst; next result 9; no spurious pulse.
